// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues PCs to a 1-cycle synchronous
//                IMem, buffers returned words in a 2-entry FIFO for decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int unsigned         ADDR_W   = 12,
    parameter int unsigned         INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_q,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               dec_ready,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc
);

    localparam logic [ADDR_W-1:0] c_pc_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0]  pc_q,     pc_d;
    logic               req_v_q,  req_v_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic [1:0]         count_q,  count_d;
    logic [INSTR_W-1:0] instr0_q, instr0_d;
    logic [INSTR_W-1:0] instr1_q, instr1_d;
    logic [ADDR_W-1:0]  pc0_q,    pc0_d;
    logic [ADDR_W-1:0]  pc1_q,    pc1_d;

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [2:0]         w_occ_after;

    always_comb begin
        imem_address = redirect_valid ? redirect_pc : pc_q;
        dec_valid    = (count_q != 2'd0) & ~redirect_valid;
        dec_instr    = instr0_q;
        dec_pc       = pc0_q;
    end

    // Occupancy counts buffered words plus the one in flight; keep it <= 2.
    always_comb begin
        w_pop       = dec_valid & dec_ready;
        w_push      = req_v_q & ~redirect_valid;
        w_occ_after = {1'b0, count_q} + {2'b00, req_v_q} - {2'b00, w_pop};
        w_issue     = (w_occ_after < 3'd2);
    end

    always_comb begin
        pc_d     = pc_q;
        req_v_d  = req_v_q;
        req_pc_d = req_pc_q;
        count_d  = count_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;

        if (redirect_valid) begin
            count_d  = 2'd0;
            req_v_d  = 1'b1;
            req_pc_d = redirect_pc;
            pc_d     = redirect_pc + c_pc_one;
        end else begin
            req_v_d = w_issue;
            if (w_issue) begin
                req_pc_d = imem_address;
                pc_d     = imem_address + c_pc_one;
            end

            // Entry 0 is always the head; entry 1 shifts down on a pop.
            case ({w_pop, w_push})
                2'b10: begin
                    instr0_d = instr1_q;
                    pc0_d    = pc1_q;
                    count_d  = count_q - 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd0) begin
                        instr0_d = imem_q;
                        pc0_d    = req_pc_q;
                    end else begin
                        instr1_d = imem_q;
                        pc1_d    = req_pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        instr0_d = imem_q;
                        pc0_d    = req_pc_q;
                    end else begin
                        instr0_d = instr1_q;
                        pc0_d    = pc1_q;
                        instr1_d = imem_q;
                        pc1_d    = req_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            req_v_q  <= 1'b0;
            req_pc_q <= '0;
            count_q  <= 2'd0;
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            req_v_q  <= req_v_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a synchronous ROM
//                model and a delivered-stream reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [11:0] imem_address;
    logic [15:0] imem_q;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        dec_ready;
    logic        dec_valid;
    logic [15:0] dec_instr;
    logic [11:0] dec_pc;

    logic [15:0] rom [0:4095];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] exp_pc;

    fetch_unit #(.ADDR_W(12), .INSTR_W(16), .RESET_PC(12'h000)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem_address   (imem_address),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) imem_q <= rom[imem_address];

    // Inputs change on the falling edge; outputs are observed 1 time unit later.
    task automatic step(input logic rv, input logic [11:0] rpc, input logic rdy);
        @(negedge clock);
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n        = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", dec_valid); end
        n_tests++; if (dec_instr !== 16'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0000", dec_instr); end
        n_tests++; if (dec_pc !== 12'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 000", dec_pc); end
        n_tests++; if (imem_address !== 12'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 000", imem_address); end
    endtask

    // ROM[i] = i + 0x100; first word two edges after release, then one per cycle.
    task automatic test_startup();
        release_reset();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) step(1'b0, 12'h000, 1'b1);
            n_tests++;
            if (dec_valid !== (k >= 2)) begin
                n_fail++; $display("FAIL startup_valid k=%0d got %0b exp %0b", k, dec_valid, (k >= 2));
            end
            n_tests++;
            if (imem_address !== 12'(k)) begin
                n_fail++; $display("FAIL startup_addr k=%0d got %h exp %h", k, imem_address, 12'(k));
            end
            if (k >= 2) begin
                n_tests++;
                if (dec_pc !== 12'(k - 2) || dec_instr !== 16'(k - 2 + 16'h0100)) begin
                    n_fail++; $display("FAIL startup_data k=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                                       k, dec_pc, dec_instr, 12'(k - 2), 16'(k - 2 + 16'h0100));
                end
                exp_pc = 12'(k - 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] held_pc;
        logic [15:0] held_instr;
        logic [11:0] held_addr;
        step(1'b0, 12'h000, 1'b0);
        held_pc    = dec_pc;
        held_instr = dec_instr;
        held_addr  = imem_address;
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_instr !== rom[exp_pc]) begin
            n_fail++; $display("FAIL stall_head got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                               dec_valid, dec_pc, dec_instr, exp_pc, rom[exp_pc]);
        end
        n_tests++;
        if (held_addr !== exp_pc + 12'd2) begin
            n_fail++; $display("FAIL stall_addr0 got %h exp %h", held_addr, exp_pc + 12'd2);
        end
        for (int s = 1; s < 5; s++) begin
            step(1'b0, 12'h000, 1'b0);
            n_tests++;
            if (dec_valid !== 1'b1 || dec_pc !== held_pc || dec_instr !== held_instr) begin
                n_fail++; $display("FAIL stall_frozen s=%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                                   s, dec_valid, dec_pc, dec_instr, held_pc, held_instr);
            end
            n_tests++;
            if (imem_address !== held_addr) begin
                n_fail++; $display("FAIL stall_addr s=%0d got %h exp %h", s, imem_address, held_addr);
            end
        end
        for (int j = 0; j < 8; j++) begin
            step(1'b0, 12'h000, 1'b1);
            n_tests++;
            if (dec_valid !== 1'b1 || dec_pc !== exp_pc || dec_instr !== rom[exp_pc]) begin
                n_fail++; $display("FAIL resume j=%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                                   j, dec_valid, dec_pc, dec_instr, exp_pc, rom[exp_pc]);
            end
            exp_pc = exp_pc + 12'd1;
        end
    endtask

    task automatic test_redirect_full();
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);
        n_tests++;
        if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin
            n_fail++; $display("FAIL rfull_pre got v=%0b pc=%h exp v=1 pc=%h", dec_valid, dec_pc, exp_pc);
        end
        step(1'b1, 12'h040, 1'b0);
        n_tests++;
        if (dec_valid !== 1'b0 || imem_address !== 12'h040) begin
            n_fail++; $display("FAIL rfull_cycle got v=%0b addr=%h exp v=0 addr=040", dec_valid, imem_address);
        end
        step(1'b0, 12'h000, 1'b1);
        n_tests++;
        if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rfull_bubble got v=%0b exp 0", dec_valid); end
        for (int j = 0; j < 2; j++) begin
            step(1'b0, 12'h000, 1'b1);
            n_tests++;
            if (dec_valid !== 1'b1 || dec_pc !== 12'(12'h040 + j) || dec_instr !== rom[12'(12'h040 + j)]) begin
                n_fail++; $display("FAIL rfull_target j=%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                                   j, dec_valid, dec_pc, dec_instr, 12'(12'h040 + j), rom[12'(12'h040 + j)]);
            end
        end
        exp_pc = 12'h042;
    endtask

    task automatic test_redirect_pop();
        logic [11:0] tgt;
        for (int r = 0; r < 4; r++) begin
            tgt = 12'($urandom_range(0, 4095));
            for (int j = 0; j < 2; j++) begin
                step(1'b0, 12'h000, 1'b1);
                n_tests++;
                if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin
                    n_fail++; $display("FAIL rpop_stream r=%0d got v=%0b pc=%h exp v=1 pc=%h", r, dec_valid, dec_pc, exp_pc);
                end
                exp_pc = exp_pc + 12'd1;
            end
            step(1'b1, tgt, 1'b1);
            n_tests++;
            if (dec_valid !== 1'b0 || imem_address !== tgt) begin
                n_fail++; $display("FAIL rpop_cycle r=%0d got v=%0b addr=%h exp v=0 addr=%h", r, dec_valid, imem_address, tgt);
            end
            step(1'b0, 12'h000, 1'b1);
            n_tests++;
            if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rpop_bubble r=%0d got v=%0b exp 0", r, dec_valid); end
            step(1'b0, 12'h000, 1'b1);
            n_tests++;
            if (dec_valid !== 1'b1 || dec_pc !== tgt || dec_instr !== rom[tgt]) begin
                n_fail++; $display("FAIL rpop_target r=%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                                   r, dec_valid, dec_pc, dec_instr, tgt, rom[tgt]);
            end
            exp_pc = tgt + 12'd1;
        end
    endtask

    task automatic test_wrap();
        logic [11:0] wrap_pcs [4];
        wrap_pcs = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        step(1'b1, 12'hFFE, 1'b1);
        step(1'b0, 12'h000, 1'b1);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 12'h000, 1'b1);
            n_tests++;
            if (dec_valid !== 1'b1 || dec_pc !== wrap_pcs[j] || dec_instr !== rom[wrap_pcs[j]]) begin
                n_fail++; $display("FAIL wrap j=%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h instr=%h",
                                   j, dec_valid, dec_pc, dec_instr, wrap_pcs[j], rom[wrap_pcs[j]]);
            end
        end
        exp_pc = 12'h002;
    endtask

    task automatic test_back_to_back();
        logic [11:0] a;
        logic [11:0] b;
        a = 12'h123;
        b = 12'h456 ^ 12'($urandom_range(0, 255));
        step(1'b1, a, 1'b1);
        n_tests++;
        if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_first got v=%0b exp 0", dec_valid); end
        step(1'b1, b, 1'b1);
        n_tests++;
        if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_second got v=%0b exp 0", dec_valid); end
        step(1'b0, 12'h000, 1'b1);
        n_tests++;
        if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble got v=%0b pc=%h exp v=0", dec_valid, dec_pc); end
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 12'h000, 1'b1);
            n_tests++;
            if (dec_valid !== 1'b1 || dec_pc !== 12'(b + j) || dec_instr !== rom[12'(b + j)]) begin
                n_fail++; $display("FAIL b2b_target j=%0d got v=%0b pc=%h exp v=1 pc=%h", j, dec_valid, dec_pc, 12'(b + j));
            end
        end
        exp_pc = 12'(b + 3);
    endtask

    task automatic test_async_reset();
        repeat (3) step(1'b0, 12'h000, 1'b1);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (dec_valid !== 1'b0 || imem_address !== 12'h000) begin
            n_fail++; $display("FAIL async_reset got v=%0b addr=%h exp v=0 addr=000", dec_valid, imem_address);
        end
        n_tests++;
        if (dec_pc !== 12'h000 || dec_instr !== 16'h0000) begin
            n_fail++; $display("FAIL async_reset_head got pc=%h instr=%h exp 000/0000", dec_pc, dec_instr);
        end
        test_startup();
    endtask

    // Reference: delivered PCs run sequentially from the last redirect target,
    // valid from the second edge after a redirect/release, and never during one.
    task automatic test_random();
        int          gap;
        logic        rv;
        logic        rdy;
        logic [11:0] rpc;
        logic        prev_hold;
        logic [11:0] prev_pc;
        logic [15:0] prev_instr;
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
        exp_pc    = 12'h000;
        gap       = 0;
        prev_hold = 1'b0;
        prev_pc   = '0;
        prev_instr = '0;
        for (int i = 0; i < 800; i++) begin
            rv  = ($urandom_range(0, 7) == 0) && (i > 0);
            rpc = 12'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            reset_n        = 1'b1;
            redirect_valid = rv;
            redirect_pc    = rpc;
            dec_ready      = rdy;
            #1;
            if (i > 0 && gap < 1000) gap++;
            n_tests++;
            if (dec_valid !== (!rv && gap >= 2)) begin
                n_fail++; $display("FAIL rand_valid i=%0d got %0b exp %0b", i, dec_valid, (!rv && gap >= 2));
            end
            if (rv) begin
                n_tests++;
                if (imem_address !== rpc) begin
                    n_fail++; $display("FAIL rand_addr i=%0d got %h exp %h", i, imem_address, rpc);
                end
            end
            if (prev_hold && !rv) begin
                n_tests++;
                if (dec_pc !== prev_pc || dec_instr !== prev_instr) begin
                    n_fail++; $display("FAIL rand_hold i=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                                       i, dec_pc, dec_instr, prev_pc, prev_instr);
                end
            end
            if (dec_valid && rdy && !rv) begin
                n_tests++;
                if (dec_pc !== exp_pc || dec_instr !== rom[exp_pc]) begin
                    n_fail++; $display("FAIL rand_data i=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                                       i, dec_pc, dec_instr, exp_pc, rom[exp_pc]);
                end
                exp_pc = exp_pc + 12'd1;
            end
            prev_hold  = dec_valid && !rdy && !rv;
            prev_pc    = dec_pc;
            prev_instr = dec_instr;
            if (rv) begin
                exp_pc = rpc;
                gap    = 0;
            end
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        exp_pc         = '0;
        for (int i = 0; i < 4096; i++) rom[i] = 16'(i + 16'h0100);
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect_full();
        test_redirect_pop();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
